// File: rtl/onewire_pkg.sv
// onewire_pkg: shared definitions for the 1-wire master sequencer, the
// onewire_rx receiver and their benches.
//   - ow_state_t    : master FSM states
//   - T_*_DEF       : default 1-wire timing, in 1 us clock cycles
//   - MAX_BYTES     : longest transaction, in bytes
//   - clamp_nbytes  : limits a requested byte count to MAX_BYTES
package onewire_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RST_LOW,
    RST_HIGH,
    SLOT,
    REC,
    DONE
  } ow_state_t;

  localparam int T_RSTL_DEF = 480;
  localparam int T_RSTH_DEF = 480;
  localparam int T_MSP_DEF  = 70;
  localparam int T_LOW1_DEF = 6;
  localparam int T_LOW0_DEF = 60;
  localparam int T_MSR_DEF  = 15;
  localparam int T_SLOT_DEF = 60;
  localparam int T_REC_DEF  = 10;
  localparam int CNT_W_DEF  = 10;

  localparam int MAX_BYTES = 8;

  function automatic logic [3:0] clamp_nbytes(input logic [3:0] n);
    return (n > 4'(MAX_BYTES)) ? 4'(MAX_BYTES) : n;
  endfunction

endpackage

// File: rtl/onewire_master_ctrl_sync.sv
// onewire_sync: 2-FF synchronizer for the raw 1-wire bus level.
// Resets to 1 so the bus reads as idle (pulled up) out of reset.
//   clk   in   system clock
//   reset in   asynchronous active-low reset
//   i_d   in   raw asynchronous input
//   o_q   out  synchronized output, 2 cycles of latency
module onewire_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_meta <= 1'b1;
      r_q    <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/onewire_master_ctrl.sv
// onewire_master_ctrl: 1-wire bus master. Each transaction sends a reset
// pulse, samples presence, then runs 8*nbytes write or read slots, LSB first.
//   clk        in   system clock, 1 MHz (1 cycle = 1 us)
//   reset      in   asynchronous active-low reset
//   i_start    in   one-cycle request, accepted only while o_busy=0
//   i_rw       in   0 = write slots, 1 = read slots
//   i_nbytes   in   byte count 0..8 (larger values clamp to 8)
//   i_wdata    in   write data, bit 0 sent first
//   i_dq       in   raw bus level
//   o_dq_oe    out  1 = pull bus low, 0 = release
//   o_rdata    out  read data, bit k from slot k
//   o_busy     out  transaction in progress
//   o_done     out  one-cycle pulse at transaction end
//   o_presence out  presence seen in last transaction
//   o_error    out  presence pulse missing during last transaction
module onewire_master_ctrl
  import onewire_pkg::*;
#(
  parameter int T_RSTL = T_RSTL_DEF,
  parameter int T_RSTH = T_RSTH_DEF,
  parameter int T_MSP  = T_MSP_DEF,
  parameter int T_LOW1 = T_LOW1_DEF,
  parameter int T_LOW0 = T_LOW0_DEF,
  parameter int T_MSR  = T_MSR_DEF,
  parameter int T_SLOT = T_SLOT_DEF,
  parameter int T_REC  = T_REC_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic        i_rw,
  input  logic [3:0]  i_nbytes,
  input  logic [63:0] i_wdata,
  input  logic        i_dq,
  output logic        o_dq_oe,
  output logic [63:0] o_rdata,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_presence,
  output logic        o_error
);

  logic             w_dq_sync;
  logic [5:0]       w_last_idx;
  logic [CNT_W-1:0] w_t_next;
  logic [CNT_W-1:0] w_slot_low;

  ow_state_t        r_state;
  logic [CNT_W-1:0] r_timer;
  logic [5:0]       r_idx;
  logic             r_rw;
  logic [3:0]       r_nbytes;
  logic [63:0]      r_wdata;
  logic             r_pres_smp;
  logic             r_oe;
  logic [63:0]      r_rdata;
  logic             r_busy;
  logic             r_done;
  logic             r_presence;
  logic             r_error;

  onewire_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (i_dq),
    .o_q   (w_dq_sync)
  );

  // Last slot index is 8*nbytes-1; only meaningful when nbytes >= 1.
  assign w_last_idx = 6'({r_nbytes, 3'b000} - 7'd1);
  assign w_t_next   = r_timer + CNT_W'(1);
  // Read slots open with the same short low pulse as a write-1.
  assign w_slot_low = (r_rw || r_wdata[r_idx]) ? CNT_W'(T_LOW1) : CNT_W'(T_LOW0);

  // o_dq_oe is computed one cycle ahead from w_t_next so the registered
  // output lines up with the timer value of the cycle it applies to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_timer    <= '0;
      r_idx      <= '0;
      r_rw       <= 1'b0;
      r_nbytes   <= '0;
      r_wdata    <= '0;
      r_pres_smp <= 1'b0;
      r_oe       <= 1'b0;
      r_rdata    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_presence <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_timer <= w_t_next;
      case (r_state)
        IDLE: begin
          r_timer <= '0;
          r_oe    <= 1'b0;
          if (i_start) begin
            r_rw       <= i_rw;
            r_nbytes   <= clamp_nbytes(i_nbytes);
            r_wdata    <= i_wdata;
            r_rdata    <= '0;
            r_presence <= 1'b0;
            r_error    <= 1'b0;
            r_busy     <= 1'b1;
            r_oe       <= 1'b1;
            r_state    <= RST_LOW;
          end
        end
        RST_LOW: begin
          if (r_timer == CNT_W'(T_RSTL - 1)) begin
            r_timer <= '0;
            r_oe    <= 1'b0;
            r_state <= RST_HIGH;
          end
        end
        RST_HIGH: begin
          if (r_timer == CNT_W'(T_MSP)) begin
            r_pres_smp <= ~w_dq_sync;
          end
          if (r_timer == CNT_W'(T_RSTH - 1)) begin
            r_timer <= '0;
            if (!r_pres_smp) begin
              r_error <= 1'b1;
              r_state <= DONE;
            end else begin
              r_presence <= 1'b1;
              if (r_nbytes == 4'd0) begin
                r_state <= DONE;
              end else begin
                r_idx   <= '0;
                r_oe    <= 1'b1;
                r_state <= SLOT;
              end
            end
          end
        end
        SLOT: begin
          if (r_rw && (r_timer == CNT_W'(T_MSR))) begin
            r_rdata[r_idx] <= w_dq_sync;
          end
          if (r_timer == CNT_W'(T_SLOT - 1)) begin
            r_timer <= '0;
            r_oe    <= 1'b0;
            r_state <= REC;
          end else begin
            r_oe <= (w_t_next < w_slot_low);
          end
        end
        REC: begin
          if (r_timer == CNT_W'(T_REC - 1)) begin
            r_timer <= '0;
            if (r_idx == w_last_idx) begin
              r_state <= DONE;
            end else begin
              r_idx   <= r_idx + 6'd1;
              r_oe    <= 1'b1;
              r_state <= SLOT;
            end
          end
        end
        DONE: begin
          r_timer <= '0;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_timer <= '0;
          r_oe    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_dq_oe    = r_oe;
  assign o_rdata    = r_rdata;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_presence = r_presence;
  assign o_error    = r_error;

endmodule
